hc_sr04_multi_ranger: RTL
=========================

Name: hc_sr04_multi_ranger

Overview:
Parametrised successor to the single-sensor HC-SR04 path. It drives NUM_CH ultrasonic sensors in round-robin, so that two sensors never fire at once and cannot pick up each other's echoes. For each sensor it generates the trig pulse, times the echo in microseconds, detects timeouts, and converts the echo time to millimetres. It replaces the separate clk_div/trig/echo blocks and feeds per-channel results to the display and control logic.

Parameters:
CLK_FREQ_HZ, 50000000, system clock frequency; one microsecond tick every CLK_FREQ_HZ/1000000 cycles.
NUM_CH, 4, number of sensors (1..8).
TRIG_US, 10, trig pulse width in microseconds.
TIMEOUT_US, 30000, maximum wait for the echo rising edge, and separately the maximum echo high time.
GAP_US, 60000, quiet time after each measurement before the next channel fires.
DIST_W, 16, width of a distance result in mm.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
enable  in  1  1 = run continuously in round-robin; 0 = single-shot mode
start  in  1  single-shot request pulse; sampled only in IDLE while enable=0
echo  in  NUM_CH  raw echo pins, asynchronous
trig  out  NUM_CH  trig pins, one-hot or zero
busy  out  1  high whenever the FSM is not in IDLE
dist_valid  out  1  one-cycle strobe when a new result is available
dist_ch  out  3  channel index of the current result
dist_mm  out  DIST_W  distance of the current result
timeout  out  1  qualifies dist_valid: 1 = no or over-long echo
dist_all  out  NUM_CH*DIST_W  last result per channel; channel k occupies bits [k*DIST_W +: DIST_W]

Behaviour:
- Reset values: trig=0, busy=0, dist_valid=0, dist_ch=0, dist_mm=0, timeout=0, dist_all all-ones, FSM=IDLE, channel pointer=0, microsecond prescaler=0.
- Input sync: each echo bit passes through a 2-flop synchronizer. Only the synchronized bit of the current channel is observed.
- us_tick: free-running prescaler, one-cycle pulse every CLK_FREQ_HZ/1000000 clocks. It restarts at 0 on every FSM state entry, so state durations are exact.
- FSM states and transitions:
  - IDLE: leave for TRIG when enable=1, or when start=1 with enable=0.
  - TRIG: trig[ch]=1 for exactly TRIG_US ticks, then go to WAIT_RISE.
  - WAIT_RISE: on a sync rising edge go to MEASURE with the us counter cleared. If TIMEOUT_US ticks elapse first, report a timeout.
  - MEASURE: the us counter increments on each tick. On a sync falling edge, compute the distance. If the count reaches TIMEOUT_US, report a timeout.
  - CALC: one cycle to register the multiply result; the result is reported and the FSM goes to GAP.
  - GAP: wait GAP_US ticks. Then ch = (ch == NUM_CH-1) ? 0 : ch+1, wrapping. Go to TRIG if enable=1. If enable=0, go to IDLE, or to TRIG while single-shot has channels left (a single shot sweeps all NUM_CH channels once).
- Distance: dist_mm = (echo_us * 11239) >> 16, i.e. a factor of about 0.1715 mm/us. The product is 32 bits wide. The result saturates to 2^DIST_W-1 if it overflows.
- Reporting:
  - dist_valid pulses for one cycle and dist_ch = ch.
  - dist_all[ch] is updated in the same cycle.
  - On a timeout: dist_mm = all-ones and timeout=1; dist_all[ch] = all-ones.
  - Latency: dist_valid rises 4 clk after the echo pin falls (2 sync + 1 edge detect + 1 CALC).
- Switching enable 1→0 mid-cycle: the current channel completes through GAP, then the FSM goes to IDLE. No truncated trig pulse is allowed.
- A start pulse while busy is ignored.
- Echo already high on entry to WAIT_RISE is not a rising edge; the channel waits for low→high or times out.
- An echo glitch shorter than 1 clk after sync is measured as-is; there is no filtering.
- Asynchronous rst mid-operation: trig drops immediately, everything returns to reset values, and the next run starts at channel 0.

Test Plan:
- CLK_FREQ_HZ=1000000 (tick every clk), NUM_CH=2, enable=1; channel 0 echo high 1000 us → dist_valid, dist_ch=0, dist_mm=171, timeout=0; trig[0] high exactly 10 clk.
- Channel 1 echo high 5830 us → dist_mm=999, dist_ch=1; dist_all[31:16]=999; dist_all[15:0] still 171.
- No echo on channel 0 with TIMEOUT_US=500 → dist_valid 500 ticks after trig falls; dist_mm=16'hFFFF, timeout=1.
- Echo stuck high for more than TIMEOUT_US → timeout=1; the FSM proceeds through GAP to the next channel; round-robin order is 0,1,0,1.
- enable=0, start pulse, NUM_CH=2 → exactly two trig pulses (ch0 then ch1), two dist_valid strobes, busy then falls. A second start while busy produces no extra pulse.
- Assert rst while trig[1] is high → trig=0 in the same cycle. After release, with enable=1, the first trig is on channel 0.

Source files
------------

// File: rtl/hc_sr04_multi_ranger.sv
// -----------------------------------------------------------------------------
// hc_sr04_multi_ranger
//   Round-robin driver for NUM_CH HC-SR04 ultrasonic sensors. Only one sensor
//   fires at a time. For each channel the block generates the trig pulse and
//   waits for the echo. It times the echo high phase in microseconds, flags
//   missing or over-long echoes, and converts the echo time to millimetres.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active-high
//   enable     1 = continuous round-robin, 0 = single-shot mode
//   start      single-shot request, sampled only in IDLE while enable=0
//   echo       raw echo pins (asynchronous), one per sensor
//   trig       trig pins, one-hot or zero
//   busy       high whenever the sequencer is not idle
//   dist_valid one-cycle strobe announcing a new result
//   dist_ch    channel index of the current result
//   dist_mm    distance of the current result (all-ones on timeout)
//   timeout    qualifies dist_valid: no echo or over-long echo
//   dist_all   last result per channel, channel k at [k*DIST_W +: DIST_W]
// -----------------------------------------------------------------------------
module hc_sr04_multi_ranger #(
   parameter int unsigned CLK_FREQ_HZ = 50000000,
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned TRIG_US     = 10,
   parameter int unsigned TIMEOUT_US  = 30000,
   parameter int unsigned GAP_US      = 60000,
   parameter int unsigned DIST_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     start,
   input  logic [NUM_CH-1:0]        echo,
   output logic [NUM_CH-1:0]        trig,
   output logic                     busy,
   output logic                     dist_valid,
   output logic [2:0]               dist_ch,
   output logic [DIST_W-1:0]        dist_mm,
   output logic                     timeout,
   output logic [NUM_CH*DIST_W-1:0] dist_all
);

   localparam int unsigned DIV    = (CLK_FREQ_HZ / 1000000 > 0) ? CLK_FREQ_HZ / 1000000 : 1;
   localparam int unsigned PW     = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned MAX_A  = (TRIG_US > TIMEOUT_US) ? TRIG_US : TIMEOUT_US;
   localparam int unsigned MAX_US = (MAX_A > GAP_US) ? MAX_A : GAP_US;
   localparam int unsigned UW     = $clog2(MAX_US + 1);
   localparam int unsigned CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [UW-1:0] TRIG_LAST  = UW'(TRIG_US - 1);
   localparam logic [UW-1:0] TO_LAST    = UW'(TIMEOUT_US - 1);
   localparam logic [UW-1:0] GAP_LAST   = UW'(GAP_US - 1);
   localparam logic [CW-1:0] CH_LAST    = CW'(NUM_CH - 1);
   localparam logic [31:0]   K_MM       = 32'd11239;   // 0.1715 mm/us in Q16
   localparam logic [32:0]   DIST_MAX   = (33'd1 << DIST_W) - 33'd1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_RISE,
      S_MEASURE,
      S_CALC,
      S_GAP
   } state_t;

   state_t            state, state_next;
   logic              state_chg;
   logic [PW-1:0]     presc;
   logic              us_tick;
   logic [UW-1:0]     us_cnt;
   logic [CW-1:0]     ch;
   logic [2:0]        shots_left;
   logic [NUM_CH-1:0] echo_s1, echo_s2;
   logic              echo_cur, echo_prev, echo_rise, echo_fall;
   logic [31:0]       prod;
   logic [31:0]       prod_shr;
   logic [DIST_W-1:0] dist_calc;
   logic              report_to;

   // ---------------------------------------------------------------- echo sync
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         echo_s1 <= '0;
         echo_s2 <= '0;
      end else begin
         echo_s1 <= echo;
         echo_s2 <= echo_s1;
      end
   end

   assign echo_cur = echo_s2[ch];

   // Tracks the current channel continuously. Echo already high when
   // WAIT_RISE is entered gives echo_prev=1, so it is not a rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) echo_prev <= 1'b0;
      else     echo_prev <= echo_cur;
   end

   assign echo_rise = echo_cur & ~echo_prev;
   assign echo_fall = ~echo_cur & echo_prev;

   // --------------------------------------------------- microsecond timebase
   // Both counters restart on every state change, so each state's duration
   // is an exact number of ticks from the cycle it was entered.
   assign state_chg = (state_next != state);
   assign us_tick   = (presc == PRESC_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                        presc <= '0;
      else if (state_chg || us_tick)  presc <= '0;
      else                            presc <= presc + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)            us_cnt <= '0;
      else if (state_chg) us_cnt <= '0;
      else if (us_tick)   us_cnt <= us_cnt + 1'b1;
   end

   // ------------------------------------------------------------ FSM: state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   // ------------------------------------------------------- FSM: next state
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:
            if (enable || start) state_next = S_TRIG;
         S_TRIG:
            if (us_tick && us_cnt == TRIG_LAST) state_next = S_WAIT_RISE;
         S_WAIT_RISE:
            if (echo_rise)                         state_next = S_MEASURE;
            else if (us_tick && us_cnt == TO_LAST) state_next = S_GAP;
         S_MEASURE:
            if (echo_fall)                         state_next = S_CALC;
            else if (us_tick && us_cnt == TO_LAST) state_next = S_GAP;
         S_CALC:
            state_next = S_GAP;
         S_GAP:
            if (us_tick && us_cnt == GAP_LAST)
               state_next = (enable || shots_left != '0) ? S_TRIG : S_IDLE;
         default:
            state_next = S_IDLE;
      endcase
   end

   // ----------------------------------------------------------- FSM: outputs
   always_comb begin
      trig = '0;
      busy = (state != S_IDLE);
      if (state == S_TRIG) trig[ch] = 1'b1;
   end

   // ----------------------------------------------- channel pointer / shots
   // shots_left counts the channels a single shot still has to cover after
   // the current one. A continuous run leaves it at zero, so dropping
   // enable finishes the current channel and then returns to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ch         <= '0;
         shots_left <= '0;
      end else begin
         if (state == S_IDLE && state_next == S_TRIG)
            shots_left <= enable ? 3'd0 : 3'(NUM_CH - 1);
         if (state == S_GAP && state_next != S_GAP) begin
            ch <= (ch == CH_LAST) ? '0 : ch + 1'b1;
            if (shots_left != '0) shots_left <= shots_left - 1'b1;
         end
      end
   end

   // --------------------------------------------------------------- datapath
   always_comb begin
      prod_shr  = prod >> 16;
      dist_calc = ({1'b0, prod_shr} > DIST_MAX) ? '1 : DIST_W'(prod_shr);
      report_to = ((state == S_WAIT_RISE) || (state == S_MEASURE)) && (state_next == S_GAP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod       <= '0;
         dist_valid <= 1'b0;
         dist_ch    <= '0;
         dist_mm    <= '0;
         timeout    <= 1'b0;
         dist_all   <= '1;
      end else begin
         dist_valid <= 1'b0;
         if (state == S_MEASURE && echo_fall)
            prod <= 32'(us_cnt) * K_MM;
         if (state == S_CALC) begin
            dist_valid                      <= 1'b1;
            dist_ch                         <= 3'(ch);
            dist_mm                         <= dist_calc;
            timeout                         <= 1'b0;
            dist_all[ch*DIST_W +: DIST_W]   <= dist_calc;
         end else if (report_to) begin
            dist_valid                      <= 1'b1;
            dist_ch                         <= 3'(ch);
            dist_mm                         <= '1;
            timeout                         <= 1'b1;
            dist_all[ch*DIST_W +: DIST_W]   <= '1;
         end
      end
   end

endmodule
